// File: rtl/bw_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bw_pkg
// Brief    : Shared types, constants and sizing helpers for the black/white
//            pixel-to-byte packer.
// Revision : 1.0 - initial release
// ============================================================================
package bw_pkg;

  localparam int BYTE_W         = 8;
  localparam int IMG_WIDTH_DEF  = 128;
  localparam int IMG_HEIGHT_DEF = 128;

  // One packed output beat: markers travel alongside the data byte.
  typedef struct packed {
    logic              frame_end;
    logic              line_end;
    logic [BYTE_W-1:0] data;
  } bw_byte_t;

  // Bytes needed to hold one padded image line.
  function automatic int bytes_per_line(input int width);
    return (width + BYTE_W - 1) / BYTE_W;
  endfunction

  // Counter width for a 0..n-1 counter; at least one bit so n=1 still works.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bw_out_reg.sv
`default_nettype none
// ============================================================================
// Module   : bw_out_reg
// Brief    : Single-entry valid/ready output register carrying one packed
//            byte with its line/frame markers. A load always wins over a
//            consume, so a back-to-back byte causes no bubble.
// Revision : 1.0 - initial release
// ============================================================================
module bw_out_reg
  import bw_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     load,
  input  bw_byte_t din,
  input  logic     ready,
  output logic     valid,
  output bw_byte_t dout
);

  logic     r_valid;
  bw_byte_t r_data;

  // Hold the entry until consumed; a new load replaces it in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (load) begin
      r_valid <= 1'b1;
      r_data  <= din;
    end else if (ready) begin
      r_valid <= 1'b0;
    end
  end

  assign valid = r_valid;
  assign dout  = r_data;

endmodule
`default_nettype wire

// File: rtl/black_white2byte.sv
`default_nettype none
// ============================================================================
// Module   : black_white2byte
// Brief    : Packs the 1-bit black/white pixel stream MSB-first into bytes.
//            Each line is padded to a whole byte with PAD_BIT; bytes carry
//            line-end and frame-end markers.
// Revision : 1.0 - initial release
// ============================================================================
module black_white2byte
  import bw_pkg::*;
#(
  parameter int   IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int   IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter logic PAD_BIT    = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bite,
  input  logic              pix_valid,
  output logic              pix_ready,
  output logic [BYTE_W-1:0] byte_data,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              line_end,
  output logic              frame_end
);

  localparam int COL_W = cnt_w(IMG_WIDTH);
  localparam int ROW_W = cnt_w(IMG_HEIGHT);
  localparam logic [COL_W-1:0] c_last_col = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] c_last_row = ROW_W'(IMG_HEIGHT - 1);

  // Only the seven previously accepted bits are kept; the eighth arrives
  // with the closing pixel and goes straight into the output register.
  logic [BYTE_W-2:0] r_sh;
  logic [2:0]        r_bit_cnt;
  logic [COL_W-1:0]  r_col_cnt;
  logic [ROW_W-1:0]  r_row_cnt;

  logic              w_accept;
  logic              w_line_last;
  logic              w_frame_last;
  logic              w_close;
  logic [BYTE_W-1:0] w_sh_next;
  logic [2:0]        w_shamt;
  logic [BYTE_W-1:0] w_aligned;
  logic [BYTE_W-1:0] w_pad_mask;
  bw_byte_t          w_new_byte;
  bw_byte_t          w_out;

  assign pix_ready    = !byte_valid || byte_ready;
  assign w_accept     = pix_valid && pix_ready;
  assign w_line_last  = (r_col_cnt == c_last_col);
  assign w_frame_last = (r_row_cnt == c_last_row);
  assign w_close      = w_accept && ((r_bit_cnt == 3'd7) || w_line_last);
  assign w_sh_next    = {r_sh, bite};

  // Left-align a short final byte and fill the vacated LSBs with PAD_BIT.
  always_comb begin
    w_shamt              = 3'd7 - r_bit_cnt;
    w_aligned            = w_sh_next << w_shamt;
    w_pad_mask           = ~(8'hFF << w_shamt);
    w_new_byte.data      = w_aligned | ({BYTE_W{PAD_BIT}} & w_pad_mask);
    w_new_byte.line_end  = w_line_last;
    w_new_byte.frame_end = w_line_last && w_frame_last;
  end

  // Shift accepted pixels in and step bit/column/row counters with explicit wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sh      <= '0;
      r_bit_cnt <= '0;
      r_col_cnt <= '0;
      r_row_cnt <= '0;
    end else if (w_accept) begin
      r_sh <= w_sh_next[BYTE_W-2:0];
      if (w_close) begin
        r_bit_cnt <= '0;
      end else begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
      if (w_line_last) begin
        r_col_cnt <= '0;
        if (w_frame_last) begin
          r_row_cnt <= '0;
        end else begin
          r_row_cnt <= r_row_cnt + 1'b1;
        end
      end else begin
        r_col_cnt <= r_col_cnt + 1'b1;
      end
    end
  end

  bw_out_reg u_out_reg (
    .clk   (clk),
    .reset (reset),
    .load  (w_close),
    .din   (w_new_byte),
    .ready (byte_ready),
    .valid (byte_valid),
    .dout  (w_out)
  );

  assign byte_data = w_out.data;
  assign line_end  = w_out.line_end;
  assign frame_end = w_out.frame_end;

endmodule
`default_nettype wire
